// File: rtl/segway_auth_ctrl.sv
// -----------------------------------------------------------------------------
// segway_auth_ctrl
//
// Authorization and power-up controller for the Segway. It consumes BLE command
// bytes from UART_rx and the rider_off status from the load-cell logic, and it
// drives pwr_up, which enables the balance loop and the motor drive. A link-loss
// watchdog treats a silent BLE link while running the same way as a STOP byte.
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous, active-high reset
//   i_rx_rdy       UART_rx byte-valid flag; stays high until acknowledged
//   i_rx_data      received byte, valid while i_rx_rdy=1
//   i_rider_off    rider has stepped off (load cells below threshold)
//   o_clr_rx_rdy   one-cycle acknowledge pulse back to UART_rx
//   o_pwr_up       high in PWR1/PWR2; enables balance loop and motors
//   o_link_lost    sticky flag, set when the watchdog expires
//   o_bad_cmd      one-cycle pulse for an accepted byte that is not GO/STOP
//   o_auth_state   current state: 00=OFF, 01=PWR1, 10=PWR2
//
// States:
//   OFF  | motors disabled, waiting for GO
//   PWR1 | authorized and running, watchdog active
//   PWR2 | stop requested, waiting for the rider to step off
// -----------------------------------------------------------------------------
module segway_auth_ctrl #(
  parameter logic [7:0]  GO_CODE     = 8'h47,
  parameter logic [7:0]  STOP_CODE   = 8'h53,
  parameter int unsigned LINK_TO_CYC = 1048576,
  parameter int unsigned TO_W        = 21
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_rdy,
  input  logic [7:0] i_rx_data,
  input  logic       i_rider_off,
  output logic       o_clr_rx_rdy,
  output logic       o_pwr_up,
  output logic       o_link_lost,
  output logic       o_bad_cmd,
  output logic [1:0] o_auth_state
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_PWR1 = 2'b01,
    ST_PWR2 = 2'b10
  } state_t;

  // Last count value before expiry: the transition fires on the edge where the
  // counter already holds this value, i.e. after exactly LINK_TO_CYC idle cycles.
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(LINK_TO_CYC - 1);

  state_t          r_state;
  state_t          w_next;
  logic            r_clr_rx_rdy;
  logic            r_pwr_up;
  logic            r_link_lost;
  logic            r_bad_cmd;
  logic [TO_W-1:0] r_wdog;

  logic w_accept;
  logic w_go;
  logic w_stop;
  logic w_timeout;
  logic w_link_set;
  logic w_link_clr;

  // The registered acknowledge blocks a second accept while UART_rx still shows
  // the same byte during the acknowledge cycle.
  assign w_accept  = i_rx_rdy & ~r_clr_rx_rdy;
  assign w_go      = w_accept & (i_rx_data == GO_CODE);
  assign w_stop    = w_accept & (i_rx_data == STOP_CODE);
  // Any accepted byte is a heartbeat, so it always beats an expiry in the same cycle.
  assign w_timeout = (r_state == ST_PWR1) & ~w_accept & (r_wdog == WD_LAST);

  always_comb begin
    w_next     = r_state;
    w_link_set = 1'b0;
    w_link_clr = 1'b0;
    case (r_state)
      ST_OFF: begin
        if (w_go) begin
          w_next     = ST_PWR1;
          w_link_clr = 1'b1;
        end
      end
      ST_PWR1: begin
        if (w_stop || w_timeout) begin
          w_next     = i_rider_off ? ST_OFF : ST_PWR2;
          w_link_set = w_timeout;
        end
      end
      ST_PWR2: begin
        // GO beats a simultaneous rider_off.
        if (w_go) begin
          w_next = ST_PWR1;
        end else if (i_rider_off) begin
          w_next = ST_OFF;
        end
      end
      default: w_next = ST_OFF;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_OFF;
      r_clr_rx_rdy <= 1'b0;
      r_pwr_up     <= 1'b0;
      r_link_lost  <= 1'b0;
      r_bad_cmd    <= 1'b0;
      r_wdog       <= '0;
    end else begin
      r_state      <= w_next;
      r_clr_rx_rdy <= w_accept;
      r_pwr_up     <= (w_next != ST_OFF);
      r_bad_cmd    <= w_accept & ~w_go & ~w_stop;

      if (w_link_clr) begin
        r_link_lost <= 1'b0;
      end else if (w_link_set) begin
        r_link_lost <= 1'b1;
      end

      // Counts only while staying in PWR1 with no accept; held at 0 elsewhere.
      if (w_accept || (w_next != r_state) || (r_state != ST_PWR1)) begin
        r_wdog <= '0;
      end else if (r_wdog != WD_LAST) begin
        r_wdog <= r_wdog + 1'b1;
      end
    end
  end

  assign o_clr_rx_rdy = r_clr_rx_rdy;
  assign o_pwr_up     = r_pwr_up;
  assign o_link_lost  = r_link_lost;
  assign o_bad_cmd    = r_bad_cmd;
  assign o_auth_state = r_state;

endmodule

// File: tb/tb_segway_auth_ctrl.sv
module tb_segway_auth_ctrl;

  localparam logic [7:0] GO   = 8'h47;
  localparam logic [7:0] STOP = 8'h53;
  localparam int         LTO  = 1000;

  logic       clk;
  logic       rst;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       rider_off;
  logic       clr_rx_rdy;
  logic       pwr_up;
  logic       link_lost;
  logic       bad_cmd;
  logic [1:0] auth_state;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  segway_auth_ctrl #(
    .GO_CODE    (GO),
    .STOP_CODE  (STOP),
    .LINK_TO_CYC(LTO),
    .TO_W       (10)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx_rdy    (rx_rdy),
    .i_rx_data   (rx_data),
    .i_rider_off (rider_off),
    .o_clr_rx_rdy(clr_rx_rdy),
    .o_pwr_up    (pwr_up),
    .o_link_lost (link_lost),
    .o_bad_cmd   (bad_cmd),
    .o_auth_state(auth_state)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state as 0=OFF 1=PWR1 2=PWR2, idle cycle count in PWR1.
  int m_state = 0;
  bit m_link  = 0;
  bit m_clr   = 0;
  bit m_bad   = 0;
  int m_idle  = 0;

  always @(posedge clk) begin : model
    bit acc, go, stp, tmo;
    int ns;
    if (rst) begin
      m_state = 0; m_link = 0; m_clr = 0; m_bad = 0; m_idle = 0;
    end else begin
      acc = rx_rdy && !m_clr;
      go  = acc && (rx_data == GO);
      stp = acc && (rx_data == STOP);
      tmo = (m_state == 1) && !acc && (m_idle + 1 >= LTO);
      ns  = m_state;
      if (m_state == 0) begin
        if (go) begin ns = 1; m_link = 0; end
      end else if (m_state == 1) begin
        if (stp || tmo) begin
          ns = rider_off ? 0 : 2;
          if (tmo) m_link = 1;
        end
      end else begin
        if (go) ns = 1;
        else if (rider_off) ns = 0;
      end
      if (ns == 1 && m_state == 1 && !acc) m_idle = m_idle + 1;
      else m_idle = 0;
      m_state = ns;
      m_clr   = acc;
      m_bad   = acc && !go && !stp;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("clr_rx_rdy", 32'(clr_rx_rdy), 32'(m_clr));
      chk("pwr_up",     32'(pwr_up),     32'(m_state != 0));
      chk("link_lost",  32'(link_lost),  32'(m_link));
      chk("bad_cmd",    32'(bad_cmd),    32'(m_bad));
      chk("auth_state", 32'(auth_state), 32'(m_state));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a byte; returns just after the accept edge.
  task automatic send(input logic [7:0] b, input logic ro);
    rx_rdy = 1; rx_data = b; rider_off = ro;
    tick();
  endtask

  // UART_rx drops rx_rdy after seeing the acknowledge.
  task automatic release_rx();
    tick();
    rx_rdy = 0;
  endtask

  initial begin
    int n;
    int pulses;
    rst = 1; rx_rdy = 1; rx_data = GO; rider_off = 0;
    @(posedge clk);
    chk_en = 1;
    #1;
    repeat (2) tick();
    chk("rst_no_ack", 32'(clr_rx_rdy), 32'd0);
    chk("rst_pwr", 32'(pwr_up), 32'd0);

    // Pending GO accepted on first edge after reset.
    rst = 0;
    tick();
    chk("go_clr", 32'(clr_rx_rdy), 32'd1);
    chk("go_pwr", 32'(pwr_up), 32'd1);
    chk("go_state", 32'(auth_state), 32'd1);
    release_rx();
    chk("go_clr_one", 32'(clr_rx_rdy), 32'd0);

    // STOP with rider on -> PWR2, then rider steps off -> OFF.
    send(STOP, 0);
    chk("stop_pwr2", 32'(auth_state), 32'd2);
    chk("stop_pwr2_pwr", 32'(pwr_up), 32'd1);
    release_rx();
    rider_off = 1;
    tick();
    chk("rider_off_state", 32'(auth_state), 32'd0);
    chk("rider_off_pwr", 32'(pwr_up), 32'd0);

    // GO in OFF ignores rider_off; STOP with rider off goes straight to OFF.
    send(GO, 1);
    chk("go_ro_state", 32'(auth_state), 32'd1);
    release_rx();
    send(STOP, 1);
    chk("stop_ro_state", 32'(auth_state), 32'd0);
    chk("stop_ro_pwr", 32'(pwr_up), 32'd0);
    release_rx();
    send(GO, 0);
    chk("re_go_state", 32'(auth_state), 32'd1);
    release_rx();

    // Watchdog with rider off: drop exactly LTO cycles after the accept.
    send(GO, 1);
    release_rx();
    n = 1;
    while (pwr_up && n < LTO + 100) begin
      tick();
      n++;
    end
    chk("wd_cycles", 32'(n), 32'd1000);
    chk("wd_link", 32'(link_lost), 32'd1);
    chk("wd_state", 32'(auth_state), 32'd0);

    // link_lost survives STOP/bad bytes in OFF, cleared by GO.
    send(STOP, 1);
    chk("off_stop_link", 32'(link_lost), 32'd1);
    release_rx();
    send(8'h00, 1);
    chk("off_bad", 32'(bad_cmd), 32'd1);
    release_rx();
    chk("off_bad_one", 32'(bad_cmd), 32'd0);
    send(GO, 0);
    chk("go_clears_link", 32'(link_lost), 32'd0);
    release_rx();

    // Heartbeat at cycle 900 restarts the watchdog; expiry at 1900 with rider on.
    send(GO, 0);
    release_rx();
    repeat (898) tick();
    send(8'h00, 0);
    chk("hb_bad", 32'(bad_cmd), 32'd1);
    release_rx();
    repeat (99) tick();
    chk("hb_no_to_pwr", 32'(pwr_up), 32'd1);
    chk("hb_no_to_state", 32'(auth_state), 32'd1);
    n = 1000;
    while (auth_state == 2'b01 && n < 2100) begin
      tick();
      n++;
    end
    chk("hb_wd_cycles", 32'(n), 32'd1900);
    chk("hb_wd_state", 32'(auth_state), 32'd2);
    chk("hb_wd_link", 32'(link_lost), 32'd1);

    // PWR2: GO and rider_off together, GO wins; link_lost stays set.
    send(GO, 1);
    chk("pwr2_go_state", 32'(auth_state), 32'd1);
    chk("pwr2_go_pwr", 32'(pwr_up), 32'd1);
    chk("pwr2_go_link", 32'(link_lost), 32'd1);
    release_rx();
    rider_off = 0;

    // Byte held on rx_rdy through the acknowledge cycle: a single accept.
    rx_rdy = 1; rx_data = GO;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pulses += int'(clr_rx_rdy);
      if (i == 1) rx_rdy = 0;
    end
    chk("hold_pulses", 32'(pulses), 32'd1);

    // STOP in PWR2 stays in PWR2, GO returns to PWR1.
    send(STOP, 0);
    chk("pwr2_enter", 32'(auth_state), 32'd2);
    release_rx();
    send(STOP, 0);
    chk("pwr2_stop_stay", 32'(auth_state), 32'd2);
    release_rx();
    send(GO, 0);
    chk("pwr2_go_back", 32'(auth_state), 32'd1);
    release_rx();

    // Reset in PWR1 with a byte pending.
    rst = 1; rx_rdy = 1; rx_data = STOP;
    tick();
    chk("rst_mid_pwr", 32'(pwr_up), 32'd0);
    chk("rst_mid_state", 32'(auth_state), 32'd0);
    chk("rst_mid_link", 32'(link_lost), 32'd0);
    tick();
    chk("rst_mid_no_ack", 32'(clr_rx_rdy), 32'd0);
    rst = 0;
    tick();
    chk("post_rst_ack", 32'(clr_rx_rdy), 32'd1);
    release_rx();
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
